// File: rtl/branch_pkg.sv
// branch_pkg: shared branch funct3 codes and 2-bit predictor counter states
package branch_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT   = 2'b00;
  localparam ctr_t CTR_WNT   = 2'b01;
  localparam ctr_t CTR_WT    = 2'b10;
  localparam ctr_t CTR_ST    = 2'b11;
  localparam ctr_t CTR_RESET = CTR_WNT;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition decode from funct3 and ALU flags
module branch_cond_eval (
  input  logic [2:0] funct3,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  input  logic       s,
  output logic       taken,
  output logic       legal
);
  import branch_pkg::*;
  always_comb begin
    legal = (funct3 != 3'b010) && (funct3 != 3'b011);
    taken = funct3 == F3_BEQ  ? z :
            funct3 == F3_BNE  ? ~z :
            funct3 == F3_BLT  ? (s ^ v) :
            funct3 == F3_BGE  ? ~(s ^ v) :
            funct3 == F3_BLTU ? ~c :
            funct3 == F3_BGEU ? c : 1'b0;
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: branch resolution, 2-bit counter prediction table and saturating statistics
module branch_predict_unit #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int STAT_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      lookup_pc,
  output logic                 predict_taken,
  input  logic                 resolve_valid,
  input  logic [XLEN-1:0]      resolve_pc,
  input  logic [2:0]           funct3,
  input  logic                 Z,
  input  logic                 C,
  input  logic                 V,
  input  logic                 S,
  input  logic                 resolve_predicted,
  output logic                 branch_taken,
  output logic                 mispredict,
  output logic                 illegal_branch,
  output logic [STAT_BITS-1:0] branch_count,
  output logic [STAT_BITS-1:0] mispredict_count
);
  import branch_pkg::*;
  localparam int DEPTH = 2 ** INDEX_BITS;
  ctr_t                  table_q [DEPTH];
  ctr_t                  cur;
  logic                  legal;
  logic                  upd;
  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] rs_idx;
  logic                  unused_pc_bits;
  branch_cond_eval u_cond (
    .funct3(funct3),
    .z     (Z),
    .c     (C),
    .v     (V),
    .s     (S),
    .taken (branch_taken),
    .legal (legal)
  );
  // no tag: PCs sharing index bits alias onto one counter
  assign lk_idx         = lookup_pc[INDEX_BITS+1:2];
  assign rs_idx         = resolve_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{lookup_pc[XLEN-1:INDEX_BITS+2], lookup_pc[1:0],
                            resolve_pc[XLEN-1:INDEX_BITS+2], resolve_pc[1:0]};
  assign cur            = table_q[rs_idx];
  assign predict_taken  = table_q[lk_idx][1];
  assign upd            = resolve_valid & legal;
  assign mispredict     = upd & (branch_taken ^ resolve_predicted);
  assign illegal_branch = resolve_valid & ~legal;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_RESET;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd) begin
      table_q[rs_idx]  <= branch_taken ? (cur == CTR_ST ? cur : cur + 2'd1)
                                       : (cur == CTR_SNT ? cur : cur - 2'd1);
      branch_count     <= &branch_count ? branch_count : branch_count + 1'b1;
      mispredict_count <= (mispredict && !(&mispredict_count)) ? mispredict_count + 1'b1
                                                                : mispredict_count;
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed plan plus randomized operand compares checked against a behavioural model
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        rst, resolve_valid, resolve_predicted, Z, C, V, S;
  logic [31:0] lookup_pc, resolve_pc;
  logic [2:0]  funct3;
  logic        predict_taken, branch_taken, mispredict, illegal_branch;
  logic [31:0] branch_count, mispredict_count;
  logic        pt_s, bt_s, mp_s, il_s;
  logic [2:0]  bc_s, mc_s;
  int          checks = 0;
  int          errors = 0;
  int          mtbl [64];
  longint      bc, mc;
  bit          exp_tk;
  logic [31:0] a, b;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .predict_taken(predict_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .funct3(funct3),
    .Z(Z), .C(C), .V(V), .S(S), .resolve_predicted(resolve_predicted),
    .branch_taken(branch_taken), .mispredict(mispredict), .illegal_branch(illegal_branch),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predict_unit #(.STAT_BITS(3)) dut_s (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .predict_taken(pt_s),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .funct3(funct3),
    .Z(Z), .C(C), .V(V), .S(S), .resolve_predicted(resolve_predicted),
    .branch_taken(bt_s), .mispredict(mp_s), .illegal_branch(il_s),
    .branch_count(bc_s), .mispredict_count(mc_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return v > m ? m : v;
  endfunction

  function automatic bit spec_taken(input logic [2:0] f, input logic [3:0] zcvs);
    case (f)
      3'b000:  return zcvs[3];
      3'b001:  return !zcvs[3];
      3'b100:  return zcvs[0] != zcvs[1];
      3'b101:  return zcvs[0] == zcvs[1];
      3'b110:  return !zcvs[2];
      3'b111:  return zcvs[2];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    foreach (mtbl[i]) mtbl[i] = 1;
    bc = 0;
    mc = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] f,
                       input logic [3:0] zcvs, input logic pred);
    resolve_valid     = v;
    resolve_pc        = pc;
    lookup_pc         = pc;
    funct3            = f;
    {Z, C, V, S}      = zcvs;
    resolve_predicted = pred;
    exp_tk            = spec_taken(f, zcvs);
  endtask

  task automatic cycle();
    bit lg, mis;
    int ri;
    #1;
    lg  = funct3 != 3'b010 && funct3 != 3'b011;
    mis = resolve_valid && lg && (exp_tk != resolve_predicted);
    check("predict", predict_taken, mtbl[lookup_pc[7:2]] >= 2);
    check("taken", branch_taken, lg && exp_tk);
    check("mispredict", mispredict, mis);
    check("illegal", illegal_branch, resolve_valid && !lg);
    @(posedge clk);
    ri = int'(resolve_pc[7:2]);
    if (rst) model_reset();
    else if (resolve_valid && lg) begin
      if (exp_tk) mtbl[ri] = mtbl[ri] == 3 ? 3 : mtbl[ri] + 1;
      else        mtbl[ri] = mtbl[ri] == 0 ? 0 : mtbl[ri] - 1;
      bc++;
      if (mis) mc++;
    end
    @(negedge clk);
    check("branch_count", branch_count, sat(bc, 32));
    check("mispredict_count", mispredict_count, sat(mc, 32));
    check("branch_count_s", bc_s, sat(bc, 3));
    check("mispredict_count_s", mc_s, sat(mc, 3));
  endtask

  initial begin
    logic [3:0] pats [5] = '{4'b0000, 4'b1000, 4'b0010, 4'b0001, 4'b0100};
    bit         preds [4] = '{0, 0, 1, 1};
    drive(0, 32'h100, 3'b000, 4'b0000, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    cycle();
    // four taken BEQs at 0x100, second one carries a stale not-taken prediction
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h100, 3'b000, 4'b1000, preds[k]);
      cycle();
    end
    drive(0, 32'h100, 3'b000, 4'b0000, 0);
    #1;
    check("pt_0x100", predict_taken, 1);
    check("bc_after_beq", branch_count, 4);
    check("mc_after_beq", mispredict_count, 2);
    for (int f = 0; f < 8; f++)
      for (int p = 0; p < 5; p++) begin
        drive(0, 32'h300, 3'(f), pats[p], 0);
        cycle();
      end
    drive(1, 32'h100, 3'b010, 4'b1000, 1);
    cycle();
    check("bc_after_illegal", branch_count, 4);
    drive(1, 32'h200, 3'b000, 4'b1000, 0);
    cycle();
    #1;
    check("pt_0x200_next", predict_taken, 1);
    for (int k = 0; k < 6; k++) begin
      drive(1, 32'h204, 3'b000, 4'b1000, 0);
      cycle();
    end
    check("mc_s_saturated", mc_s, 3'h7);
    drive(1, 32'h100, 3'b001, 4'b0000, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(0, 32'h100, 3'b000, 4'b0000, 0);
    #1;
    check("pt_after_rst", predict_taken, 0);
    check("bc_after_rst", branch_count, 0);
    check("mc_after_rst", mispredict_count, 0);
    for (int n = 0; n < 3000; n++) begin
      logic [32:0] diff;
      a                 = $urandom;
      b                 = ($urandom_range(0, 3) == 0) ? a : $urandom;
      diff              = {1'b0, a} - {1'b0, b};
      Z                 = a == b;
      C                 = a >= b;
      S                 = diff[31];
      V                 = (a[31] != b[31]) && (diff[31] != a[31]);
      funct3            = 3'($urandom_range(0, 7));
      case (funct3)
        3'b000:  exp_tk = a == b;
        3'b001:  exp_tk = a != b;
        3'b100:  exp_tk = $signed(a) < $signed(b);
        3'b101:  exp_tk = $signed(a) >= $signed(b);
        3'b110:  exp_tk = a < b;
        3'b111:  exp_tk = a >= b;
        default: exp_tk = 0;
      endcase
      resolve_pc        = $urandom & 32'hFFFF_F03F;
      lookup_pc         = $urandom_range(0, 1) ? resolve_pc : ($urandom & 32'hFFFF_F03F);
      resolve_valid     = $urandom_range(0, 3) != 0;
      resolve_predicted = $urandom_range(0, 3) != 0 ? (mtbl[resolve_pc[7:2]] >= 2) : 1'($urandom);
      rst               = $urandom_range(0, 99) == 0;
      cycle();
    end
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
